cache_meta_ram: RTL and testbench
=================================

Name: cache_meta_ram

Overview:
- Parametrised N-way set-associative cache metadata store. Holds valid bit, dirty bit and tag per way per set.
- Performs registered hit detection and victim selection for the cache controller.
- Successor to the single-bit valid RAM: it adds multi-way storage, tags, dirty tracking and a replacement pointer.
- Clears itself with a sequential flush sweep instead of an instantaneous array clear.

Parameters:
SETS, 256, number of sets; power of two, >= 2
WAYS, 2, associativity; power of two, 1..8
TAGW, 20, tag width in bits
INDEXW, $clog2(SETS), set index width (derived)
WAYW, max(1,$clog2(WAYS)), way select width (derived)

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
lookup_en  in  1  request lookup this cycle
lookup_index  in  INDEXW  set to look up
lookup_tag  in  TAGW  tag to compare
lookup_valid  out  1  lookup result outputs valid this cycle
hit  out  1  tag matched a valid way
hit_way  out  WAYW  matching way
hit_dirty  out  1  dirty bit of matching way
victim_way  out  WAYW  way to replace in looked-up set
victim_valid  out  1  valid bit of victim way
victim_dirty  out  1  dirty bit of victim way (writeback needed)
victim_tag  out  TAGW  tag of victim way
wr_en  in  1  metadata write request
wr_op  in  2  00 fill, 01 set-dirty, 10 invalidate, 11 reserved (no-op)
wr_index  in  INDEXW  target set
wr_way  in  WAYW  target way
wr_tag  in  TAGW  tag for fill
wr_dirty  in  1  dirty value for fill
flush_start  in  1  begin invalidate-all sweep
busy  out  1  flush sweep in progress

Behaviour:
- FSM states: FLUSH, IDLE.
- Reset (reset low, asynchronous):
  - FSM goes to FLUSH and the sweep counter goes to 0.
  - busy=1.
  - lookup_valid, hit, hit_way, hit_dirty, victim_* all 0.
- Reset deassertion: the sweep runs.
- FLUSH:
  - Each cycle clears valid, dirty and the replacement pointer of set[counter], then increments the counter.
  - After set SETS-1 is cleared: counter wraps to 0, FSM goes to IDLE, busy=0 on the following cycle.
  - Sweep length is exactly SETS cycles. Tags are not cleared.
- flush_start in IDLE: goes to FLUSH with counter 0 next cycle. flush_start while busy is ignored.
- While busy: lookup_en and wr_en are ignored; lookup_valid stays 0.
- Lookup:
  - lookup_en in IDLE registers the results; lookup_valid=1 exactly one cycle later.
  - Outputs hold their last values while lookup_valid=0.
- Hit:
  - hit=1 if any way has valid=1 and tag==lookup_tag.
  - Multiple matches (controller error): the lowest-numbered way is reported.
  - On miss, hit_way=0 and hit_dirty=0.
- Victim:
  - Lowest-numbered invalid way if any exists, else the set's round-robin pointer.
  - victim_valid, victim_dirty and victim_tag come from that way.
  - Victim is computed whether hit or miss.
- Write ops (IDLE only, take effect on the clock edge):
  - Fill: tag=wr_tag, valid=1, dirty=wr_dirty; set pointer = (wr_way+1) mod WAYS.
  - Set-dirty: dirty=1 only if the way is valid; otherwise no change.
  - Invalidate: valid=0, dirty=0; pointer unchanged.
- Same-cycle lookup and write to the same set: the lookup returns pre-write contents (read-before-write).
  - A write followed by a lookup on the next cycle sees the new contents.
- WAYS=1: victim_way=0 always; the pointer is unused.
- Reset asserted mid-flush or mid-lookup: aborts immediately and restarts the full sweep from set 0.

Test Plan:
- Reset pulse, SETS=256 -> busy=1 for exactly 256 cycles after deassertion; a lookup of index 5 afterwards gives hit=0, victim_way=0, victim_valid=0.
- Fill set 3 way 1 with tag 0xABCDE, dirty 0, then lookup (3, 0xABCDE) -> next cycle lookup_valid=1, hit=1, hit_way=1, hit_dirty=0; victim_way=0 (way 0 invalid).
- Fill set 7 ways 0 and 1 (tags 0x11, 0x22), then set-dirty way 0, then lookup (7, 0x33) -> hit=0, victim_way=0 (pointer=0 after way-1 fill), victim_dirty=1, victim_tag=0x11.
- Same cycle: fill set 9 way 0 tag 0x44 and lookup (9, 0x44) -> hit=0; repeat the lookup next cycle -> hit=1.
- After valid fills, pulse flush_start and lookup during busy -> lookup_valid stays 0. After 256 cycles, lookup of a filled tag -> hit=0.
- Assert reset at sweep count 100 -> busy stays 1; after deassertion the sweep takes a full 256 cycles; set-dirty to an invalid way -> a subsequent lookup shows victim_dirty=0.

Source files
------------

// File: rtl/cache_meta_ram_if.sv
// cache_meta_ram_if: lookup, write and flush bus between cache controller and metadata store
interface cache_meta_ram_if #(
    parameter int SETS = 256,
    parameter int WAYS = 2,
    parameter int TAGW = 20
);
    localparam int INDEXW = $clog2(SETS);
    localparam int WAYW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    logic              lookup_en;
    logic [INDEXW-1:0] lookup_index;
    logic [TAGW-1:0]   lookup_tag;
    logic              lookup_valid;
    logic              hit;
    logic [WAYW-1:0]   hit_way;
    logic              hit_dirty;
    logic [WAYW-1:0]   victim_way;
    logic              victim_valid;
    logic              victim_dirty;
    logic [TAGW-1:0]   victim_tag;
    logic              wr_en;
    logic [1:0]        wr_op;
    logic [INDEXW-1:0] wr_index;
    logic [WAYW-1:0]   wr_way;
    logic [TAGW-1:0]   wr_tag;
    logic              wr_dirty;
    logic              flush_start;
    logic              busy;
    modport master (
        output lookup_en, lookup_index, lookup_tag, wr_en, wr_op, wr_index, wr_way, wr_tag, wr_dirty, flush_start,
        input  lookup_valid, hit, hit_way, hit_dirty, victim_way, victim_valid, victim_dirty, victim_tag, busy
    );
    modport slave (
        input  lookup_en, lookup_index, lookup_tag, wr_en, wr_op, wr_index, wr_way, wr_tag, wr_dirty, flush_start,
        output lookup_valid, hit, hit_way, hit_dirty, victim_way, victim_valid, victim_dirty, victim_tag, busy
    );
endinterface

// File: rtl/cache_meta_ram.sv
// cache_meta_ram: N-way set-associative valid/dirty/tag store with registered hit and victim lookup
module cache_meta_ram #(
    parameter int SETS = 256,
    parameter int WAYS = 2,
    parameter int TAGW = 20
) (
    input logic clock,
    input logic reset,
    cache_meta_ram_if.slave bus
);
    localparam int INDEXW = $clog2(SETS);
    localparam int WAYW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {FLUSH, IDLE} state_t;

    state_t            state_q, state_d;
    logic [INDEXW-1:0] cnt_q, cnt_d;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [TAGW-1:0]   tag_q   [SETS][WAYS];
    logic [WAYW-1:0]   ptr_q   [SETS];

    logic              fire;
    logic              hit_d, hit_dirty_d, inv_d, vic_valid_d, vic_dirty_d;
    logic [WAYW-1:0]   hit_way_d, inv_way_d, vic_way_d;
    logic [TAGW-1:0]   vic_tag_d;
    logic              lookup_valid_q, hit_q, hit_dirty_q, vic_valid_q, vic_dirty_q;
    logic [WAYW-1:0]   hit_way_q, vic_way_q;
    logic [TAGW-1:0]   vic_tag_q;

    assign fire = bus.lookup_en && state_q == IDLE;

    // Sweep sequencing: FLUSH walks every set once, then IDLE until flush_start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == FLUSH) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == INDEXW'(SETS - 1)) ? IDLE : FLUSH;
        end else if (bus.flush_start) begin
            state_d = FLUSH;
            cnt_d   = '0;
        end
    end

    // FSM state and sweep counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Metadata arrays: sweep clears one set per cycle, otherwise apply controller writes; tags survive the sweep
    always_ff @(posedge clock) begin
        if (state_q == FLUSH) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
            ptr_q[cnt_q]   <= '0;
        end else if (bus.wr_en) begin
            if (bus.wr_op == 2'b00) begin
                tag_q[bus.wr_index][bus.wr_way]   <= bus.wr_tag;
                valid_q[bus.wr_index][bus.wr_way] <= 1'b1;
                dirty_q[bus.wr_index][bus.wr_way] <= bus.wr_dirty;
                ptr_q[bus.wr_index]               <= (WAYS == 1) ? '0 : WAYW'(bus.wr_way + 1'b1);
            end else if (bus.wr_op == 2'b01) begin
                if (valid_q[bus.wr_index][bus.wr_way])
                    dirty_q[bus.wr_index][bus.wr_way] <= 1'b1;
            end else if (bus.wr_op == 2'b10) begin
                valid_q[bus.wr_index][bus.wr_way] <= 1'b0;
                dirty_q[bus.wr_index][bus.wr_way] <= 1'b0;
            end
        end
    end

    // Hit search and victim choice; descending scan makes the lowest-numbered way win
    always_comb begin
        hit_d       = 1'b0;
        hit_way_d   = '0;
        hit_dirty_d = 1'b0;
        inv_d       = 1'b0;
        inv_way_d   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[bus.lookup_index][w] && tag_q[bus.lookup_index][w] == bus.lookup_tag) begin
                hit_d       = 1'b1;
                hit_way_d   = WAYW'(w);
                hit_dirty_d = dirty_q[bus.lookup_index][w];
            end
            if (!valid_q[bus.lookup_index][w]) begin
                inv_d     = 1'b1;
                inv_way_d = WAYW'(w);
            end
        end
        vic_way_d   = (WAYS == 1) ? '0 : inv_d ? inv_way_d : ptr_q[bus.lookup_index];
        vic_valid_d = valid_q[bus.lookup_index][vic_way_d];
        vic_dirty_d = dirty_q[bus.lookup_index][vic_way_d];
        vic_tag_d   = tag_q[bus.lookup_index][vic_way_d];
    end

    // Lookup result registers; hold their last values between lookups
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lookup_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            hit_way_q      <= '0;
            hit_dirty_q    <= 1'b0;
            vic_way_q      <= '0;
            vic_valid_q    <= 1'b0;
            vic_dirty_q    <= 1'b0;
            vic_tag_q      <= '0;
        end else begin
            lookup_valid_q <= fire;
            if (fire) begin
                hit_q       <= hit_d;
                hit_way_q   <= hit_way_d;
                hit_dirty_q <= hit_dirty_d;
                vic_way_q   <= vic_way_d;
                vic_valid_q <= vic_valid_d;
                vic_dirty_q <= vic_dirty_d;
                vic_tag_q   <= vic_tag_d;
            end
        end
    end

    assign bus.lookup_valid = lookup_valid_q;
    assign bus.hit          = hit_q;
    assign bus.hit_way      = hit_way_q;
    assign bus.hit_dirty    = hit_dirty_q;
    assign bus.victim_way   = vic_way_q;
    assign bus.victim_valid = vic_valid_q;
    assign bus.victim_dirty = vic_dirty_q;
    assign bus.victim_tag   = vic_tag_q;
    assign bus.busy         = state_q == FLUSH;
endmodule

// File: tb/tb_cache_meta_ram.sv
// tb_cache_meta_ram: directed vector table plus flush/reset sequences for cache_meta_ram
module tb_cache_meta_ram;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    cache_meta_ram_if #(.SETS(256), .WAYS(2), .TAGW(20)) bus ();
    cache_meta_ram #(.SETS(256), .WAYS(2), .TAGW(20)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic        le;
        logic [7:0]  li;
        logic [19:0] lt;
        logic        we;
        logic [1:0]  op;
        logic [7:0]  wi;
        logic        ww;
        logic [19:0] wt;
        logic        wd;
        logic        h, hw, hd, vw, vv, vd, ct;
        logic [19:0] vt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic le, logic [7:0] li, logic [19:0] lt, logic we, logic [1:0] op, logic [7:0] wi,
                                logic ww, logic [19:0] wt, logic wd, logic h, logic hw, logic hd, logic vw,
                                logic vv, logic vd, logic [19:0] vt, logic ct);
        vec_t v;
        v.le = le; v.li = li; v.lt = lt; v.we = we; v.op = op; v.wi = wi; v.ww = ww; v.wt = wt; v.wd = wd;
        v.h = h; v.hw = hw; v.hd = hd; v.vw = vw; v.vv = vv; v.vd = vd; v.vt = vt; v.ct = ct;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.lookup_en = 0; bus.lookup_index = 0; bus.lookup_tag = 0;
        bus.wr_en = 0; bus.wr_op = 0; bus.wr_index = 0; bus.wr_way = 0; bus.wr_tag = 0; bus.wr_dirty = 0;
        bus.flush_start = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [7:0] i, input logic w, input logic [19:0] t, input logic d);
        idle_in();
        bus.wr_en = 1; bus.wr_op = op; bus.wr_index = i; bus.wr_way = w; bus.wr_tag = t; bus.wr_dirty = d;
        step();
        idle_in();
    endtask

    task automatic lk(input logic [7:0] i, input logic [19:0] t);
        idle_in();
        bus.lookup_en = 1; bus.lookup_index = i; bus.lookup_tag = t;
        step();
        idle_in();
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (bus.busy && n < 1000) begin
            step();
            n++;
        end
        chk(name, n, 256);
    endtask

    initial begin
        vec_t e;
        idle_in();
        #3 reset = 0;
        step();
        step();
        chk("rst_busy", bus.busy, 1);
        chk("rst_lv", bus.lookup_valid, 0);
        chk("rst_hit", {bus.hit, bus.hit_way, bus.hit_dirty}, 0);
        chk("rst_victim", {bus.victim_way, bus.victim_valid, bus.victim_dirty, bus.victim_tag}, 0);
        reset = 1;
        count_busy("initial_sweep_len");

        //         le li  lt       we op  wi  ww wt       wd   h hw hd vw vv vd vt       ct
        tv.push_back(mk(1, 5, 0,       0, 0, 0,  0, 0,       0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(0, 0, 0,       1, 0, 3,  1, 'hABCDE, 0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 3, 'hABCDE, 0, 0, 0,  0, 0,       0,   1, 1, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(0, 0, 0,       1, 0, 7,  0, 'h11,    0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(0, 0, 0,       1, 0, 7,  1, 'h22,    0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(0, 0, 0,       1, 1, 7,  0, 0,       0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 7, 'h33,    0, 0, 0,  0, 0,       0,   0, 0, 0, 0, 1, 1, 'h11,    1));
        tv.push_back(mk(1, 7, 'h22,    0, 0, 0,  0, 0,       0,   1, 1, 0, 0, 1, 1, 'h11,    1));
        tv.push_back(mk(1, 9, 'h44,    1, 0, 9,  0, 'h44,    0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 9, 'h44,    0, 0, 0,  0, 0,       0,   1, 0, 0, 1, 0, 0, 0,       0));
        tv.push_back(mk(0, 0, 0,       1, 2, 7,  0, 0,       0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 7, 'h11,    0, 0, 0,  0, 0,       0,   0, 0, 0, 0, 0, 0, 'h11,    1));
        tv.push_back(mk(0, 0, 0,       1, 0, 7,  0, 'h55,    1,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 7, 'h55,    0, 0, 0,  0, 0,       0,   1, 0, 1, 1, 1, 0, 'h22,    1));
        tv.push_back(mk(0, 0, 0,       1, 3, 7,  1, 'h55,    1,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 7, 'h22,    0, 0, 0,  0, 0,       0,   1, 1, 0, 1, 1, 0, 'h22,    1));
        tv.push_back(mk(0, 0, 0,       1, 1, 7,  1, 0,       0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 7, 'h22,    0, 0, 0,  0, 0,       0,   1, 1, 1, 1, 1, 1, 'h22,    1));
        tv.push_back(mk(0, 0, 0,       1, 0, 7,  1, 'h55,    0,   0, 0, 0, 0, 0, 0, 0,       0));
        tv.push_back(mk(1, 7, 'h55,    0, 0, 0,  0, 0,       0,   1, 0, 1, 0, 1, 1, 'h55,    1));
        tv.push_back(mk(1, 3, 'hABCDF, 0, 0, 0,  0, 0,       0,   0, 0, 0, 0, 0, 0, 0,       0));

        e = tv[0];
        foreach (tv[k]) begin
            bus.lookup_en = tv[k].le; bus.lookup_index = tv[k].li; bus.lookup_tag = tv[k].lt;
            bus.wr_en = tv[k].we; bus.wr_op = tv[k].op; bus.wr_index = tv[k].wi; bus.wr_way = tv[k].ww;
            bus.wr_tag = tv[k].wt; bus.wr_dirty = tv[k].wd;
            step();
            if (tv[k].le) e = tv[k];
            chk($sformatf("v%0d_lv", k), bus.lookup_valid, tv[k].le);
            chk($sformatf("v%0d_hit", k), {bus.hit, bus.hit_way, bus.hit_dirty}, {e.h, e.hw, e.hd});
            chk($sformatf("v%0d_victim", k), {bus.victim_way, bus.victim_valid, bus.victim_dirty}, {e.vw, e.vv, e.vd});
            if (e.ct) chk($sformatf("v%0d_vtag", k), bus.victim_tag, e.vt);
        end
        idle_in();

        // Flush sweep: lookups, a re-flush and a write during busy must all be ignored
        wr(2'b00, 12, 0, 'h777, 0);
        lk(12, 'h777);
        chk("preflush_hit", bus.hit, 1);
        bus.flush_start = 1;
        step();
        bus.flush_start = 0;
        chk("flush_busy", bus.busy, 1);
        begin
            int n = 0;
            int seen = 0;
            while (bus.busy && n < 1000) begin
                bus.lookup_en = 1; bus.lookup_index = 12; bus.lookup_tag = 'h777;
                bus.flush_start = (n == 50);
                bus.wr_en = (n == 200); bus.wr_op = 0; bus.wr_index = 11; bus.wr_way = 0; bus.wr_tag = 'h99;
                step();
                n++;
                seen += int'(bus.lookup_valid);
            end
            idle_in();
            chk("flush_sweep_len", n, 256);
            chk("flush_lv_while_busy", seen, 0);
        end
        lk(12, 'h777);
        chk("postflush_lv", bus.lookup_valid, 1);
        chk("postflush_hit", {bus.hit, bus.victim_valid, bus.victim_dirty}, 0);
        lk(11, 'h99);
        chk("busy_write_ignored", bus.hit, 0);

        // Reset in mid-sweep restarts the full sweep
        wr(2'b00, 30, 1, 'h5, 1);
        lk(30, 'h5);
        chk("prereset_hit", {bus.hit, bus.hit_way, bus.hit_dirty}, 3'b111);
        bus.flush_start = 1;
        step();
        bus.flush_start = 0;
        repeat (100) step();
        reset = 0;
        #2;
        chk("async_rst_outputs", {bus.lookup_valid, bus.hit, bus.hit_way, bus.hit_dirty}, 0);
        chk("async_rst_busy", bus.busy, 1);
        step();
        step();
        chk("held_rst_busy", bus.busy, 1);
        reset = 1;
        count_busy("restart_sweep_len");
        wr(2'b01, 20, 0, 0, 0);
        lk(20, 0);
        chk("sd_invalid_lv", bus.lookup_valid, 1);
        chk("sd_invalid_victim", {bus.hit, bus.victim_way, bus.victim_valid, bus.victim_dirty}, 0);
        lk(30, 'h5);
        chk("postreset_miss", bus.hit, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
